relu_stream_ctrl: RTL and testbench

- Sequencer that streams one feature-map tile from the input activation buffer through the ReLU datapath and into the output buffer.
- Instantiates the N-bit combinational ReLU stage.
- Issues buffer reads, applies ReLU, writes results in order under write-side backpressure, and counts zeroed elements for sparsity stats.
- Sits between the conv/accumulate output buffer and the next layer's input buffer; started by the layer controller.

---
 rtl/relu_stream_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_relu_stream_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl: streams a tile from the input buffer through ReLU into the output buffer.
// Optional RELU_CLAMP_EN: clamp non-negative results to CLAMP_MAX (ReLU6-style).

module relu_stage #(
   parameter int N = 16,
   parameter logic [N-1:0] CLAMP_MAX = 16'h0600
) (
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic         neg
);

`ifndef RELU_CLAMP_EN
   logic unused_clamp;
   assign unused_clamp = ^CLAMP_MAX;
`endif

   // zero negatives, optionally clamp large positives
   always_comb begin
      neg  = din[N-1];
      dout = din;
      if (neg) begin
         dout = '0;
`ifdef RELU_CLAMP_EN
      end else if ($signed(din) > $signed(CLAMP_MAX)) begin
         dout = CLAMP_MAX;
`endif
      end
   end

endmodule

module relu_stream_ctrl #(
   parameter int N = 16,
   parameter int ADDR_W = 12,
   parameter int LEN_W = 12,
   parameter logic [N-1:0] CLAMP_MAX = 16'h0600
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [ADDR_W-1:0] cfg_rd_base,
   input  logic [ADDR_W-1:0] cfg_wr_base,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [N-1:0]      rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [N-1:0]      wr_data,
   input  logic              wr_ready,
   output logic [LEN_W-1:0]  neg_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  rd_cnt;
   logic [LEN_W-1:0]  wr_cnt;
   logic [LEN_W-1:0]  wr_cnt_nx;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr;

   logic         rd_pend;
   logic         out_v;
   logic [N-1:0] out_data;
   logic         out_neg;
   logic         skid_v;
   logic [N-1:0] skid_data;
   logic         skid_neg;

   logic [N-1:0] relu_y;
   logic         relu_neg;
   logic         hs;
   logic         free;
   logic         room;
   logic         rd_go;
   logic         accept;
   logic [1:0]   occ;

   relu_stage #(
      .N         (N),
      .CLAMP_MAX (CLAMP_MAX)
   ) u_relu (
      .din  (rd_data),
      .dout (relu_y),
      .neg  (relu_neg)
   );

   assign hs        = out_v & wr_ready;
   assign free      = ~out_v | hs;
   assign occ       = 2'(out_v) + 2'(skid_v) + 2'(rd_pend);
   assign room      = (occ - 2'(hs)) < 2'd2;
   assign wr_cnt_nx = wr_cnt + LEN_W'(hs);

   assign rd_en   = rd_go;
   assign rd_addr = rd_ptr;
   assign wr_en   = out_v;
   assign wr_addr = wr_ptr;
   assign wr_data = out_data;

   // job sequencing: next state, busy/done, read issue
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      rd_go   = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               // empty job still shows one busy cycle
               state_d = (cfg_len == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            busy  = 1'b1;
            rd_go = (rd_cnt != len_q) & room;
            if (rd_cnt + LEN_W'(rd_go) == len_q)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (wr_cnt_nx == len_q)
               state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // job counters, address pointers and sparsity count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q     <= '0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         neg_count <= '0;
      end else if (accept) begin
         len_q     <= cfg_len;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         rd_ptr    <= cfg_rd_base;
         wr_ptr    <= cfg_wr_base;
         neg_count <= '0;
      end else begin
         if (rd_go) begin
            rd_cnt <= rd_cnt + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (hs) begin
            wr_cnt <= wr_cnt_nx;
            wr_ptr <= wr_ptr + 1'b1;
            if (out_neg && !(&neg_count))
               neg_count <= neg_count + 1'b1;
         end
      end
   end

   // two-entry output/skid storage fed by returning reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pend   <= 1'b0;
         out_v     <= 1'b0;
         out_data  <= '0;
         out_neg   <= 1'b0;
         skid_v    <= 1'b0;
         skid_data <= '0;
         skid_neg  <= 1'b0;
      end else begin
         rd_pend <= rd_go;
         if (free) begin
            if (skid_v) begin
               out_v     <= 1'b1;
               out_data  <= skid_data;
               out_neg   <= skid_neg;
               skid_v    <= rd_pend;
               skid_data <= relu_y;
               skid_neg  <= relu_neg;
            end else if (rd_pend) begin
               out_v    <= 1'b1;
               out_data <= relu_y;
               out_neg  <= relu_neg;
            end else begin
               out_v <= 1'b0;
            end
         end else if (rd_pend) begin
            skid_v    <= 1'b1;
            skid_data <= relu_y;
            skid_neg  <= relu_neg;
         end
      end
   end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb_relu_stream_ctrl: random and directed jobs checked against a queue-based model.
// Build with RELU_CLAMP_EN to exercise the clamp case.

module tb_relu_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [11:0] cfg_len;
   logic [11:0] cfg_rd_base;
   logic [11:0] cfg_wr_base;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [15:0] rd_data;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic [11:0] neg_count;

   always #5 clk = ~clk;

   relu_stream_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_len     (cfg_len),
      .cfg_rd_base (cfg_rd_base),
      .cfg_wr_base (cfg_wr_base),
      .busy        (busy),
      .done        (done),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .neg_count   (neg_count)
   );

   logic [15:0] mem [0:4095];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_relu(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      if (v < 0) return 16'h0000;
`ifdef RELU_CLAMP_EN
      if (v > 32'sh600) return 16'h0600;
`endif
      return x;
   endfunction

   // model state
   bit          in_job = 0;
   int          exp_len, exp_neg;
   int          rd_seen, wr_seen;
   int          start_cyc, last_hs_cyc;
   int          first_rd_cyc, first_wr_cyc, done_cyc;
   int          cyc = 0;
   logic [11:0] exp_rd_base;
   logic [11:0] exp_addr_q[$];
   logic [15:0] exp_data_q[$];
   logic [11:0] wlog_a[$];
   logic [15:0] wlog_d[$];
   logic [11:0] rlog[$];

   // input buffer: data one cycle after rd_en, garbage otherwise
   always @(posedge clk)
      rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

   int rdy_mode = 0;
   int rdy_ctr = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: wr_ready = 1'b1;
         1: wr_ready = (rdy_ctr % 3 == 0);
         default: wr_ready = ($urandom_range(0, 3) != 0);
      endcase
      rdy_ctr++;
   end

   // cycle-by-cycle compare against the model
   bit          hs, exp_done, prev_stall = 0;
   logic [11:0] sv_addr, ea;
   logic [15:0] sv_data, ed;
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         hs = wr_en && wr_ready;
         exp_done = 0;
         if (in_job) begin
            exp_done = (wr_seen == exp_len) && (cyc == last_hs_cyc + 1);
            check("busy", busy, cyc > start_cyc && !exp_done);
            check("done", done, exp_done);
            check("occupancy_le2", (rd_seen - wr_seen) <= 2, 1);
         end else begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_rd_en", rd_en, 0);
            check("idle_wr_en", wr_en, 0);
         end
         if (rd_en) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            ea = exp_rd_base + 12'(rd_seen);
            check("rd_addr", rd_addr, ea);
            check("rd_in_range", rd_seen < exp_len, 1);
            rlog.push_back(rd_addr);
            rd_seen++;
         end
         if (prev_stall) begin
            check("stall_wr_en", wr_en, 1);
            check("stall_wr_addr", wr_addr, sv_addr);
            check("stall_wr_data", wr_data, sv_data);
         end
         if (wr_en && first_wr_cyc < 0) first_wr_cyc = cyc;
         if (hs) begin
            if (exp_data_q.size() == 0) begin
               check("extra_write", wr_addr, 32'hFFFF_FFFF);
            end else begin
               ea = exp_addr_q.pop_front();
               ed = exp_data_q.pop_front();
               check("wr_addr", wr_addr, ea);
               check("wr_data", wr_data, ed);
            end
            wlog_a.push_back(wr_addr);
            wlog_d.push_back(wr_data);
            wr_seen++;
            last_hs_cyc = cyc;
         end
         prev_stall = wr_en && !wr_ready;
         sv_addr = wr_addr;
         sv_data = wr_data;
         if (in_job && exp_done) begin
            check("neg_count", neg_count, exp_neg);
            done_cyc = cyc;
            in_job = 0;
         end
      end
   end

   task automatic start_job(input int len,
                            input logic [11:0] rdb,
                            input logic [11:0] wrb);
      logic [11:0] a;
      @(posedge clk);
      #1;
      cfg_len = 12'(len);
      cfg_rd_base = rdb;
      cfg_wr_base = wrb;
      start = 1'b1;
      exp_addr_q.delete();
      exp_data_q.delete();
      wlog_a.delete();
      wlog_d.delete();
      rlog.delete();
      exp_neg = 0;
      for (int k = 0; k < len; k++) begin
         a = rdb + 12'(k);
         exp_addr_q.push_back(wrb + 12'(k));
         exp_data_q.push_back(ref_relu(mem[a]));
         if (mem[a][15]) exp_neg++;
      end
      exp_len = len;
      exp_rd_base = rdb;
      rd_seen = 0;
      wr_seen = 0;
      start_cyc = cyc + 1;
      last_hs_cyc = (len == 0) ? start_cyc + 1 : -10;
      first_rd_cyc = -1;
      first_wr_cyc = -1;
      done_cyc = -1;
      in_job = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && in_job; i++) @(posedge clk);
      check("job_timeout", in_job, 0);
      in_job = 0;
      repeat (2) @(posedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_neg_count"}, neg_count, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cfg_len = '0;
      cfg_rd_base = '0;
      cfg_wr_base = '0;
      wr_ready = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // basic job
      mem[12'h010] = 16'h0005;
      mem[12'h011] = 16'hFFFE;
      mem[12'h012] = 16'h7FFF;
      mem[12'h013] = 16'h8000;
      rdy_mode = 0;
      start_job(4, 12'h010, 12'h200);
      wait_done();
      check("basic_nwr", wlog_d.size(), 4);
      if (wlog_d.size() == 4) begin
         check("basic_a0", wlog_a[0], 12'h200);
         check("basic_a3", wlog_a[3], 12'h203);
         check("basic_d0", wlog_d[0], 16'h0005);
         check("basic_d1", wlog_d[1], 16'h0000);
         check("basic_d2", wlog_d[2], 16'h7FFF);
         check("basic_d3", wlog_d[3], 16'h0000);
      end
      check("basic_neg", neg_count, 2);
      check("basic_latency", first_wr_cyc - first_rd_cyc, 2);
      check("basic_done_cyc", done_cyc - start_cyc, 7);

      // backpressure 1,0,0,...
      rdy_mode = 1;
      start_job(8, 12'h100, 12'h300);
      wait_done();
      check("bp_nwr", wlog_d.size(), 8);

      // zero length
      rdy_mode = 0;
      start_job(0, 12'h020, 12'h030);
      wait_done();
      check("zero_done_cyc", done_cyc - start_cyc, 2);
      check("zero_neg", neg_count, 0);
      check("zero_nwr", wlog_d.size(), 0);

      // wrap plus starts while busy and during done
      rdy_mode = 2;
      start_job(4, 12'hFFE, 12'hFFF);
      repeat (2) @(posedge clk);
      #1;
      cfg_len = 12'd2;
      cfg_rd_base = 12'h111;
      cfg_wr_base = 12'h222;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 3000 && in_job && wr_seen != exp_len; i++)
         @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      check("wrap_nrd", rlog.size(), 4);
      if (rlog.size() == 4) begin
         check("wrap_r0", rlog[0], 12'hFFE);
         check("wrap_r1", rlog[1], 12'hFFF);
         check("wrap_r2", rlog[2], 12'h000);
         check("wrap_r3", rlog[3], 12'h001);
      end
      check("wrap_nwr", wlog_d.size(), 4);
      repeat (3) @(posedge clk);

      // reset mid-job
      rdy_mode = 0;
      start_job(10, 12'h500, 12'h600);
      for (int i = 0; i < 200 && wr_seen < 3; i++) @(posedge clk);
      #1 rst_n = 1'b0;
      in_job = 0;
      @(negedge clk);
      @(negedge clk);
      check_outputs_zero("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // job after reset, then random jobs
      rdy_mode = 2;
      start_job(6, 12'h700, 12'h710);
      wait_done();
      check("post_rst_nwr", wlog_d.size(), 6);
      for (int j = 0; j < 10; j++) begin
         rdy_mode = $urandom_range(0, 2);
         start_job($urandom_range(1, 24),
                   12'($urandom), 12'($urandom));
         wait_done();
      end

`ifdef RELU_CLAMP_EN
      mem[12'h400] = 16'h0700;
      mem[12'h401] = 16'h0600;
      mem[12'h402] = 16'hFFFF;
      rdy_mode = 0;
      start_job(3, 12'h400, 12'h000);
      wait_done();
      check("clamp_nwr", wlog_d.size(), 3);
      if (wlog_d.size() == 3) begin
         check("clamp_d0", wlog_d[0], 16'h0600);
         check("clamp_d1", wlog_d[1], 16'h0600);
         check("clamp_d2", wlog_d[2], 16'h0000);
      end
      check("clamp_neg", neg_count, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
